envelope_adsr: RTL and testbench
================================

# envelope_adsr

Per-voice ADSR amplitude envelope. It sits directly downstream of the oscillator mix and upstream of the PWM DAC. It takes the 16-bit unsigned oscillator sample and a key gate from the button decoder, and outputs the sample scaled by a 4-phase envelope (attack, decay, sustain, release) stepped on a prescaled tick.

## Interface
- `TICK_DIV`, 256: clk cycles per envelope step tick; legal range 2..65536.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `gate` input 1: key held (1) or released (0); synchronous to `clk`.
- `attack_rate` input 8: attack step per tick = `attack_rate`+1 (units of 1/65536 full scale).
- `decay_rate` input 8: decay step per tick = `decay_rate`+1.
- `sustain_level` input 8: sustain target; accumulator target = {`sustain_level`, 8'h00}.
- `release_rate` input 8: release step per tick = `release_rate`+1.
- `sample_in` input 16: unsigned PCM from oscillator/mixer.
- `sample_out` output 16: (`sample_in` × `env_out`) >> 8, registered.
- `env_out` output 8: current envelope level = acc[15:8].
- `phase` output 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active` output 1: high when `phase` != IDLE.

## Operation
- Internal state: 16-bit accumulator `acc`, registered `gate_d`, tick prescaler counter, phase register.
- `rise` = `gate` & ~`gate_d`; `fall` = ~`gate` & `gate_d`.
- Tick: the prescaler counts 0..TICK_DIV-1 and is free-running from reset. `tick` is high for one cycle when count == TICK_DIV-1.
- Gate edges act on the next clk edge regardless of tick:
  - `rise` in any phase → ATTACK; `acc` is kept, unless retrigger-reset applies (see Configuration).
  - `fall` in ATTACK, DECAY or SUSTAIN → RELEASE.
  - `fall` in IDLE or RELEASE → no effect.
- On `tick` with no edge:
  - ATTACK: `acc` += step, saturating at 16'hFFFF. On reaching 16'hFFFF → DECAY.
  - DECAY: `acc` -= step. If the result is ≤ target, `acc` = target → SUSTAIN.
  - SUSTAIN: `acc` holds.
  - RELEASE: `acc` -= step, floored at 0. On reaching 0 → IDLE.
  - IDLE: `acc` = 0.
- Arithmetic: add and subtract are computed 17 bits wide and then clamped. No wrap-around is permitted.
- Sustain 0: DECAY ends at `acc`=0 and enters SUSTAIN, not IDLE. The phase stays SUSTAIN with `env_out`=0 until `fall`.
- Rate inputs are sampled on every tick. A change mid-phase takes effect at the next tick.
- Multiply: 16×8 unsigned, product bits [23:8]. `env_out`=0xFF gives `sample_in`×255/256 (not unity). This is by design.

## Timing
- Reset values: `acc`=0, `gate_d`=0, prescaler=0, `phase`=IDLE, `env_out`=0, `sample_out`=0, `active`=0.
- Reset mid-operation drops everything to reset values immediately. The first tick after deassertion occurs TICK_DIV cycles later.
- Gate edge to phase change: 1 cycle after `gate` toggles at a clk edge. The `phase` output is registered.
- Edge and tick in the same cycle: the phase transition wins and no `acc` step occurs that tick.
- `env_out` updates in the cycle after the tick.
- `sample_out` latency: 1 cycle. `sample_out`[n+1] = f(`sample_in`[n], `env_out`[n]).
- Full-scale attack with `attack_rate`=255 takes 256 ticks.

## Configuration
- Macro: `ENVELOPE_RETRIGGER_RESET_EN`.
- Defined: `rise` from RELEASE, DECAY or SUSTAIN also clears `acc` to 0 in the same cycle it enters ATTACK (hard retrigger).
- Undefined: `rise` enters ATTACK from the current `acc` (soft retrigger, no click). `rise` from IDLE is identical in both builds since `acc` is already 0.

## Test plan
- Reset: assert `rst` asynchronously mid-ATTACK with `acc`≈0x4000 → all outputs 0 and `phase`=0 without waiting for a clock edge.
- Full cycle, TICK_DIV=4, rates A=255, D=15, S=0x80, R=63:
  - Hold `gate` → ATTACK for 256 ticks to `env_out`=0xFF.
  - DECAY for ceil(0x7FFF/16)=2048 ticks to `env_out`=0x80, then SUSTAIN.
  - Drop `gate` → RELEASE for 512 ticks to 0, then IDLE with `active`=0.
- Scaling: `sample_in`=0xFFFF held in SUSTAIN with `env_out`=0x80 → `sample_out`=0x7FFF one cycle later. With `env_out`=0 → 0.
- Early release: drop `gate` at ATTACK `env_out`=0x40 → RELEASE next cycle, `acc` monotone down to 0, no jump.
- Retrigger: raise `gate` in RELEASE at `env_out`=0x30 → ATTACK.
  - Build without macro: continues from 0x30.
  - Build with `ENVELOPE_RETRIGGER_RESET_EN`: `env_out`=0 next cycle.
- Edge/tick collision: toggle `gate` exactly on a tick cycle → phase changes and `acc` is unchanged that cycle.

Source files
------------

// File: rtl/envelope_adsr.sv
// envelope_adsr: per-voice ADSR amplitude envelope.
// Scales the 16-bit oscillator sample by an 8-bit envelope level that walks
// through attack, decay, sustain and release, stepping once per prescaled tick.
// Optional build macro: ENVELOPE_RETRIGGER_RESET_EN
//   defined   -> a key press from DECAY/SUSTAIN/RELEASE restarts attack from 0
//   undefined -> a key press restarts attack from the current level
module envelope_adsr #(
    parameter int unsigned TICK_DIV = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_rate,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic [7:0]  env_out,
    output logic [2:0]  phase,
    output logic        active
);

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;

    // Last prescaler count; 16 bits covers the full legal TICK_DIV range.
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    // Add with saturation at full scale; the sum is formed 17 bits wide.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [8:0] s);
        logic [16:0] sum;
        sum = {1'b0, a} + {8'h00, s};
        if (sum[16]) begin
            sat_add = 16'hFFFF;
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

    // Subtract with a floor; a borrow or a result at/below the floor yields the floor.
    function automatic logic [15:0] sub_floor(input logic [15:0] a, input logic [8:0] s,
                                              input logic [15:0] floor_v);
        logic [16:0] diff;
        diff = {1'b0, a} - {8'h00, s};
        if (diff[16] || (diff[15:0] <= floor_v)) begin
            sub_floor = floor_v;
        end else begin
            sub_floor = diff[15:0];
        end
    endfunction

    phase_e      phase_q, phase_d;
    logic [15:0] acc_q, acc_d;
    logic        gate_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sample_q;

    logic        tick_s;
    logic        rise_s;
    logic        fall_s;
    logic [8:0]  att_step_s;
    logic [8:0]  dec_step_s;
    logic [8:0]  rel_step_s;
    logic [15:0] target_s;
    logic [15:0] att_acc_s;
    logic [15:0] dec_acc_s;
    logic [15:0] rel_acc_s;
    logic [23:0] prod_s;

    assign tick_s     = (cnt_q == TICK_LAST);
    assign rise_s     = gate & ~gate_q;
    assign fall_s     = ~gate & gate_q;
    assign att_step_s = {1'b0, attack_rate} + 9'd1;
    assign dec_step_s = {1'b0, decay_rate} + 9'd1;
    assign rel_step_s = {1'b0, release_rate} + 9'd1;
    assign target_s   = {sustain_level, 8'h00};
    assign att_acc_s  = sat_add(acc_q, att_step_s);
    assign dec_acc_s  = sub_floor(acc_q, dec_step_s, target_s);
    assign rel_acc_s  = sub_floor(acc_q, rel_step_s, 16'h0000);
    assign prod_s     = {8'h00, sample_in} * {16'h0000, env_out};

    // Free-running tick prescaler: wraps to 0 after TICK_LAST.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (tick_s) begin
            cnt_d = 16'h0000;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Envelope FSM: gate edges take priority over the tick step.
    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        if (rise_s) begin
            phase_d = PH_ATTACK;
`ifdef ENVELOPE_RETRIGGER_RESET_EN
            if ((phase_q == PH_DECAY) || (phase_q == PH_SUSTAIN) || (phase_q == PH_RELEASE)) begin
                acc_d = 16'h0000;
            end else begin
                acc_d = acc_q;
            end
`else
            acc_d = acc_q;
`endif
        end else if (fall_s && ((phase_q == PH_ATTACK) || (phase_q == PH_DECAY) ||
                                (phase_q == PH_SUSTAIN))) begin
            phase_d = PH_RELEASE;
        end else if (tick_s) begin
            case (phase_q)
                PH_ATTACK: begin
                    acc_d = att_acc_s;
                    if (att_acc_s == 16'hFFFF) begin
                        phase_d = PH_DECAY;
                    end else begin
                        phase_d = PH_ATTACK;
                    end
                end
                PH_DECAY: begin
                    acc_d = dec_acc_s;
                    if (dec_acc_s == target_s) begin
                        phase_d = PH_SUSTAIN;
                    end else begin
                        phase_d = PH_DECAY;
                    end
                end
                PH_SUSTAIN: begin
                    acc_d = acc_q;
                end
                PH_RELEASE: begin
                    acc_d = rel_acc_s;
                    if (rel_acc_s == 16'h0000) begin
                        phase_d = PH_IDLE;
                    end else begin
                        phase_d = PH_RELEASE;
                    end
                end
                PH_IDLE: begin
                    acc_d = 16'h0000;
                end
                default: begin
                    phase_d = PH_IDLE;
                    acc_d   = 16'h0000;
                end
            endcase
        end else begin
            phase_d = phase_q;
            acc_d   = acc_q;
        end
    end

    // State, prescaler, gate history and scaled sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_IDLE;
            acc_q    <= 16'h0000;
            gate_q   <= 1'b0;
            cnt_q    <= 16'h0000;
            sample_q <= 16'h0000;
        end else begin
            phase_q  <= phase_d;
            acc_q    <= acc_d;
            gate_q   <= gate;
            cnt_q    <= cnt_d;
            sample_q <= prod_s[23:8];
        end
    end

    assign sample_out = sample_q;
    assign env_out    = acc_q[15:8];
    assign phase      = phase_q;
    assign active     = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed self-checking bench for envelope_adsr (TICK_DIV=4).
// Expected values are hand-computed from edge counts; ticks step the envelope
// on every 4th clock edge after reset release.
module tb_envelope_adsr;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  sustain_level;
    logic [7:0]  release_rate;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic [7:0]  env_out;
    logic [2:0]  phase;
    logic        active;

    int n_cmp;
    int n_bad;
    int ecount;

    envelope_adsr #(.TICK_DIV(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .env_out       (env_out),
        .phase         (phase),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after absolute clock edge e (counted from reset release).
    task automatic goto_edge(input int e);
        while (ecount < e) begin
            @(posedge clk);
            ecount++;
        end
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ecount = 0;
        rst = 1'b1;
        gate = 1'b0;
        attack_rate = 8'd255;
        decay_rate = 8'd15;
        sustain_level = 8'h80;
        release_rate = 8'd63;
        sample_in = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_env", 16'(env_out), 16'h0000);
        chk("rst_phase", 16'(phase), 16'h0000);
        chk("rst_active", 16'(active), 16'h0000);
        chk("rst_sample", sample_out, 16'h0000);

        // Full cycle
        rst = 1'b0;
        ecount = 0;
        gate = 1'b1;
        goto_edge(3);
        chk("att_phase", 16'(phase), 16'h0001);
        chk("att_env0", 16'(env_out), 16'h0000);
        chk("att_active", 16'(active), 16'h0001);
        goto_edge(4);
        chk("att_env1", 16'(env_out), 16'h0001);
        goto_edge(1023);
        chk("att_end_phase", 16'(phase), 16'h0001);
        chk("att_end_env", 16'(env_out), 16'h00FF);
        goto_edge(1024);
        chk("dec_phase", 16'(phase), 16'h0002);
        chk("dec_env", 16'(env_out), 16'h00FF);
        goto_edge(1088);
        chk("dec_env16", 16'(env_out), 16'h00FE);
        goto_edge(9215);
        chk("dec_end_phase", 16'(phase), 16'h0002);
        chk("dec_end_env", 16'(env_out), 16'h0080);
        goto_edge(9216);
        chk("sus_phase", 16'(phase), 16'h0003);
        chk("sus_env", 16'(env_out), 16'h0080);
        sample_in = 16'hFFFF;
        goto_edge(9217);
        chk("scale_ffff", sample_out, 16'h7FFF);
        sample_in = 16'h1234;
        goto_edge(9218);
        chk("scale_1234", sample_out, 16'h091A);
        chk("sus_hold_env", 16'(env_out), 16'h0080);
        gate = 1'b0;
        goto_edge(9219);
        chk("rel_phase", 16'(phase), 16'h0004);
        chk("rel_env0", 16'(env_out), 16'h0080);
        goto_edge(9220);
        chk("rel_env1", 16'(env_out), 16'h007F);
        goto_edge(11263);
        chk("rel_end_phase", 16'(phase), 16'h0004);
        chk("rel_end_env", 16'(env_out), 16'h0000);
        chk("rel_end_active", 16'(active), 16'h0001);
        goto_edge(11264);
        chk("idle_phase", 16'(phase), 16'h0000);
        chk("idle_active", 16'(active), 16'h0000);
        sample_in = 16'hFFFF;
        goto_edge(11265);
        chk("scale_zero", sample_out, 16'h0000);

        // Early release from ATTACK at env 0x40
        gate = 1'b1;
        goto_edge(11266);
        chk("att2_phase", 16'(phase), 16'h0001);
        goto_edge(11520);
        chk("att2_env", 16'(env_out), 16'h0040);
        gate = 1'b0;
        goto_edge(11521);
        chk("early_rel_phase", 16'(phase), 16'h0004);
        chk("early_rel_env", 16'(env_out), 16'h0040);
        goto_edge(11524);
        chk("early_rel_step", 16'(env_out), 16'h003F);
        goto_edge(11776);
        chk("rel2_env30", 16'(env_out), 16'h0030);

        // Retrigger from RELEASE at env 0x30
        gate = 1'b1;
        goto_edge(11777);
        chk("retrig_phase", 16'(phase), 16'h0001);
`ifdef ENVELOPE_RETRIGGER_RESET_EN
        chk("retrig_env", 16'(env_out), 16'h0000);
        goto_edge(11780);
        chk("retrig_step", 16'(env_out), 16'h0001);
        goto_edge(11840);
        chk("retrig_env16", 16'(env_out), 16'h0010);
        chk("pre_rst_sample", sample_out, 16'h0EFF);
`else
        chk("retrig_env", 16'(env_out), 16'h0030);
        goto_edge(11780);
        chk("retrig_step", 16'(env_out), 16'h0031);
        goto_edge(11840);
        chk("retrig_env16", 16'(env_out), 16'h0040);
        chk("pre_rst_sample", sample_out, 16'h3EFF);
`endif

        // Asynchronous reset mid-ATTACK, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_env", 16'(env_out), 16'h0000);
        chk("arst_phase", 16'(phase), 16'h0000);
        chk("arst_active", 16'(active), 16'h0000);
        chk("arst_sample", sample_out, 16'h0000);
        gate = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ecount = 0;

        // Edge/tick collisions (ticks land on edges 4, 8, 12, ...)
        goto_edge(3);
        gate = 1'b1;
        goto_edge(4);
        chk("col_rise_phase", 16'(phase), 16'h0001);
        chk("col_rise_env", 16'(env_out), 16'h0000);
        goto_edge(12);
        chk("col_att_env", 16'(env_out), 16'h0002);
        goto_edge(15);
        gate = 1'b0;
        goto_edge(16);
        chk("col_fall_phase", 16'(phase), 16'h0004);
        chk("col_fall_env", 16'(env_out), 16'h0002);
        goto_edge(19);
        gate = 1'b1;
        goto_edge(20);
        chk("col_rise2_phase", 16'(phase), 16'h0001);
`ifdef ENVELOPE_RETRIGGER_RESET_EN
        chk("col_rise2_env", 16'(env_out), 16'h0000);
        goto_edge(24);
        chk("col_after_env", 16'(env_out), 16'h0001);
`else
        chk("col_rise2_env", 16'(env_out), 16'h0002);
        goto_edge(24);
        chk("col_after_env", 16'(env_out), 16'h0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
